song_reader: RTL and testbench

//  Playback-side partner of the MCU control FSM. Consumes play/reset_play/nextsong, returns song_done.

---
 rtl/mcu_pkg.sv | 10 +
 rtl/song_reader.sv | 80 ++++++++
 tb/tb_song_reader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// mcu_pkg: shared widths, end-of-song marker and state encoding for song_reader
package mcu_pkg;
  localparam int NUM_SONGS = 4;
  localparam int SONG_W = $clog2(NUM_SONGS);
  localparam int SONG_AW = 5;
  localparam int NOTE_W = 6;
  localparam int DUR_W = 6;
  localparam logic [DUR_W-1:0] DUR_END = '0;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, END} state_t;
endpackage

// File: rtl/song_reader.sv
// song_reader: walks the song ROM note by note and hands notes to the player; SONG_READER_AUTO_NEXT_EN advances the song at END
module song_reader
  import mcu_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic                      reset_play,
  input  logic                      nextsong,
  output logic                      song_done,
  output logic [SONG_W+SONG_AW-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic                      new_note,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  input  logic                      note_done,
  output logic [SONG_W-1:0]         song
);
`ifdef SONG_READER_AUTO_NEXT_EN
  localparam logic AUTO_NEXT = 1'b1;
`else
  localparam logic AUTO_NEXT = 1'b0;
`endif
  state_t state, state_d;
  logic [SONG_AW-1:0] addr, addr_d;
  logic [SONG_W-1:0] song_d;
  logic nn, nn_d, latch, inc;
  // The ROM is addressed with next-cycle values so its data is already valid in FETCH
  assign rom_addr = {song_d, addr_d};
  assign new_note = nn && !reset_play;
  assign song_done = state == END && !reset_play;
  // Next-state, note-address and song-number logic; reset_play overrides the FSM
  always_comb begin
    state_d = state;
    addr_d = addr;
    latch = 1'b0;
    case (state)
      IDLE: state_d = play ? FETCH : IDLE;
      FETCH: begin
        latch = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: state_d = nn ? WAIT : END;
      WAIT: if (note_done) begin
        state_d = &addr ? END : (play ? FETCH : IDLE);
        addr_d = &addr ? addr : addr + 1'b1;
      end
      END: begin
        state_d = IDLE;
        addr_d = '0;
      end
      default: state_d = IDLE;
    endcase
    if (reset_play) begin
      state_d = IDLE;
      addr_d = '0;
      latch = 1'b0;
    end
    nn_d = latch && rom_data[DUR_W-1:0] != DUR_END;
    inc = nextsong || (AUTO_NEXT && state == END && !reset_play);
    song_d = song + SONG_W'(inc);
  end
  // State, counters and the note/duration hold registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      song <= '0;
      addr <= '0;
      nn <= 1'b0;
      note <= '0;
      duration <= '0;
    end else begin
      state <= state_d;
      song <= song_d;
      addr <= addr_d;
      nn <= nn_d;
      if (nn_d) {note, duration} <= rom_data;
    end
  end
endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: directed scoreboard bench for song_reader with a synchronous ROM model
module tb_song_reader;
  logic clk = 0, reset = 1, play = 0, reset_play = 0, nextsong = 0, note_done = 0;
  logic song_done, new_note;
  logic [6:0] rom_addr;
  logic [11:0] rom_data;
  logic [5:0] note, duration;
  logic [1:0] song;
  logic [11:0] rom [128];
  logic [11:0] exp_q[$];
  int checks = 0, failures = 0, nn_cnt = 0, sd_cnt = 0, pushed = 0, sd_exp = 0, sd_before = 0, nn_before = 0;
  song_reader dut (.clk(clk), .reset(reset), .play(play), .reset_play(reset_play), .nextsong(nextsong),
    .song_done(song_done), .rom_addr(rom_addr), .rom_data(rom_data), .new_note(new_note), .note(note),
    .duration(duration), .note_done(note_done), .song(song));
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (new_note) begin
      nn_cnt++;
      if (exp_q.size() == 0) chk("nn_unexpected", exp_q.size(), 1);
      else chk("nn_data", {note, duration}, exp_q.pop_front());
    end
    if (song_done) sd_cnt++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [5:0] n, input logic [5:0] d);
    exp_q.push_back({n, d});
    pushed++;
  endtask
  task automatic pulse_done();
    note_done = 1;
    step();
    note_done = 0;
  endtask
  task automatic rp(input logic ns);
    reset_play = 1;
    nextsong = ns;
    step();
    reset_play = 0;
    nextsong = 0;
  endtask
  task automatic first_note(input logic [5:0] n, input logic [5:0] d);
    push(n, d);
    play = 1;
    step();
    step();
    @(negedge clk);
    chk("lat_play", new_note, 1);
    step();
  endtask
  task automatic next_note(input logic [5:0] n, input logic [5:0] d);
    push(n, d);
    pulse_done();
    step();
    @(negedge clk);
    chk("lat_done", new_note, 1);
    step();
  endtask
  task automatic goto_song(input logic [1:0] s);
    for (int i = 0; i < 4 && song != s; i++) rp(1);
    rp(0);
    chk("goto_song", song, s);
  endtask
  initial begin
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[0] = {6'd5, 6'd3};
    rom[1] = {6'd7, 6'd2};
    rom[32] = {6'd9, 6'd4};
    for (int i = 0; i < 32; i++) rom[64+i] = {6'(i), 6'(i + 1)};
    for (int i = 0; i < 32; i++) rom[96+i] = {6'(i + 10), 6'd1};
    step();
    step();
    @(negedge clk);
    chk("rst_song", song, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_outs", {new_note, song_done, note, duration}, 0);
    step();
    reset = 0;
    first_note(5, 3);
    next_note(7, 2);
    pulse_done();
    step();
    @(negedge clk);
    chk("end_no_nn", new_note, 0);
    step();
    play = 0;
    @(negedge clk);
    chk("song_done", song_done, 1);
    sd_exp++;
    step();
    @(negedge clk);
    chk("done_single", song_done, 0);
    chk("note_held", {note, duration}, {6'd7, 6'd2});
    rp(0);
    first_note(5, 3);
    play = 0;
    nn_before = nn_cnt;
    pulse_done();
    repeat (4) step();
    @(negedge clk);
    chk("pause_no_nn", nn_cnt, nn_before);
    chk("pause_addr", rom_addr, 1);
    first_note(7, 2);
    pulse_done();
    step();
    step();
    @(negedge clk);
    chk("song_done2", song_done, 1);
    sd_exp++;
    play = 0;
    step();
    goto_song(3);
    first_note(10, 1);
    for (int i = 1; i < 10; i++) next_note(6'(i + 10), 1);
    play = 0;
    reset_play = 1;
    @(negedge clk);
    chk("rp_no_nn", new_note, 0);
    chk("rp_no_done", song_done, 0);
    step();
    reset_play = 0;
    @(negedge clk);
    chk("rp_addr", rom_addr, 7'h60);
    first_note(10, 1);
    play = 0;
    rp(0);
    rp(1);
    @(negedge clk);
    chk("wrap_song", song, 0);
    chk("wrap_addr", rom_addr, 0);
    goto_song(2);
    first_note(0, 1);
    for (int i = 1; i < 32; i++) next_note(6'(i), 6'(i + 1));
    sd_before = sd_cnt;
    chk("no_early_done", sd_cnt, sd_exp);
    pulse_done();
    play = 0;
    @(negedge clk);
    chk("done32", song_done, 1);
    sd_exp++;
    step();
    @(negedge clk);
    chk("addr_wrap", rom_addr[4:0], 0);
`ifdef SONG_READER_AUTO_NEXT_EN
    chk("song_after32", song, 3);
`else
    chk("song_after32", song, 2);
`endif
    goto_song(1);
    first_note(9, 4);
    pulse_done();
    step();
    play = 0;
    step();
    @(negedge clk);
    chk("done_s1", song_done, 1);
    sd_exp++;
    step();
    @(negedge clk);
`ifdef SONG_READER_AUTO_NEXT_EN
    chk("auto_next", song, 2);
`else
    chk("auto_next", song, 1);
`endif
    goto_song(1);
    first_note(9, 4);
    pulse_done();
    step();
    play = 0;
    step();
    nextsong = 1;
    @(negedge clk);
    chk("done_s1b", song_done, 1);
    sd_exp++;
    step();
    nextsong = 0;
    @(negedge clk);
    chk("next_in_end", song, 2);
    step();
    chk("queue_empty", exp_q.size(), 0);
    chk("nn_total", nn_cnt, pushed);
    chk("sd_total", sd_cnt, sd_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
